kv_srl_fifo_wr_arb: RTL and testbench

//  Round-robin write arbiter sharing one kv_srl_fifo write port among NREQ producers.

---
 rtl/kv_srl_fifo_wr_arb_pkg.sv | 21 ++
 rtl/kv_srl_fifo_wr_arb_pick.sv | 34 +++
 rtl/kv_srl_fifo_wr_arb.sv | 159 +++++++++++++++
 tb/tb_kv_srl_fifo_wr_arb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_srl_fifo_wr_arb_pkg.sv
// Shared types and constants for the kv_srl_fifo write arbiter.
// Holds the FSM state encoding, the index and counter widths, and a modular increment.
package kv_srl_fifo_wr_arb_pkg;

  localparam int OWNER_W = 3;   // wide enough for up to 8 requesters
  localparam int BCNT_W  = 8;   // burst beat counter, MAX_BURST <= 255
  localparam int STATS_W = 16;  // per-requester beat counter width

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Next index after i, wrapping at n.
  function automatic logic [OWNER_W-1:0] inc_mod(input logic [OWNER_W-1:0] i,
                                                 input int n);
    if (int'(i) + 1 >= n) return '0;
    return i + 1'b1;
  endfunction

endpackage

// File: rtl/kv_srl_fifo_wr_arb_pick.sv
// kv_rr_pick: rotate-priority encoder. The first set req at or after ptr wins,
// scanning ptr, ptr+1, ... modulo NREQ. Purely combinational.
module kv_rr_pick
  import kv_srl_fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [NREQ-1:0]    grant,
  output logic [OWNER_W-1:0] idx,
  output logic               any
);

  int j;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise unassigned paths infer latches.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = OWNER_W'(j);
      end
    end
  end

endmodule

// File: rtl/kv_srl_fifo_wr_arb.sv
// Round-robin write arbiter sharing one kv_srl_fifo write port among NREQ producers,
// with req_last-framed burst locking. Optional beat counters: KV_SRL_FIFO_WR_ARB_STATS_EN.
module kv_srl_fifo_wr_arb
  import kv_srl_fifo_wr_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*WIDTH-1:0]   req_d,
  output logic [NREQ-1:0]         ack,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_d,
  input  logic                    fifo_full,
  input  logic                    fifo_err_ovr,
  output logic [OWNER_W-1:0]      owner,
  output logic                    locked,
  output logic                    trunc,
  output logic                    err,
  output logic [NREQ*STATS_W-1:0] stats
);

  localparam logic [BCNT_W:0] MAX_BURST_V = (BCNT_W+1)'(MAX_BURST);

  state_t             state_q, state_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               trunc_q, trunc_d;
  logic               err_q;

  logic [NREQ-1:0]    pick_grant;
  logic [OWNER_W-1:0] pick_idx;
  logic               pick_any;
  logic [NREQ-1:0]    grant_vec;
  logic [OWNER_W-1:0] g_idx;
  logic               last_g;
  logic               burst_end;

  kv_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // In LOCK only the owner may be granted; in IDLE the rotating pick decides.
  always_comb begin
    grant_vec = '0;
    g_idx     = pick_idx;
    if (state_q == ST_LOCK) begin
      g_idx = owner_q;
      for (int i = 0; i < NREQ; i++) grant_vec[i] = (owner_q == OWNER_W'(i));
    end else if (pick_any) begin
      grant_vec = pick_grant;
    end
  end

  // rst_n gates ack so a reset asserted mid-burst blocks the write in that same cycle.
  assign ack        = req & grant_vec & {NREQ{~fifo_full & rst_n}};
  assign fifo_wr_en = |ack;

  always_comb begin
    fifo_d = '0;
    last_g = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        fifo_d = req_d[i*WIDTH +: WIDTH];
        last_g = req_last[i];
      end
    end
  end

  assign burst_end = (({1'b0, bcnt_q} + 1'b1) == MAX_BURST_V);

  // Nothing advances without an ack, so fifo_full freezes state, ptr and bcnt.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    trunc_d = 1'b0;
    if (fifo_wr_en) begin
      case (state_q)
        ST_IDLE: begin
          owner_d = g_idx;
          if (last_g || MAX_BURST == 1) begin
            ptr_d = inc_mod(g_idx, NREQ);
          end else begin
            state_d = ST_LOCK;
            bcnt_d  = BCNT_W'(1);
          end
        end
        ST_LOCK: begin
          bcnt_d = bcnt_q + 1'b1;
          if (last_g || burst_end) begin
            state_d = ST_IDLE;
            ptr_d   = inc_mod(owner_q, NREQ);
            trunc_d = ~last_g;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      bcnt_q  <= '0;
      trunc_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
      trunc_q <= trunc_d;
      err_q   <= err_q | fifo_err_ovr;
    end
  end

  assign owner  = owner_q;
  assign locked = (state_q == ST_LOCK);
  assign trunc  = trunc_q;
  assign err    = err_q;

`ifdef KV_SRL_FIFO_WR_ARB_STATS_EN
  logic [STATS_W-1:0] cnt_q [NREQ];

  // Saturating per-requester beat counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else if (ack[i] && cnt_q[i] != '1) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stats = '0;
    for (int i = 0; i < NREQ; i++) stats[i*STATS_W +: STATS_W] = cnt_q[i];
  end
`else
  assign stats = '0;
`endif

endmodule

// File: tb/tb_kv_srl_fifo_wr_arb.sv
// Self-checking bench for kv_srl_fifo_wr_arb: directed steps, a FIFO model,
// and a scoreboard of expected writes popped as the arbiter writes.
module tb_kv_srl_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] d;
    logic       locked;
    logic       trunc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_d = '0;

  logic        fifo_full_a = 1'b0;
  logic        fifo_err_ovr_a = 1'b0;
  logic        fifo_full_b = 1'b0;
  logic        fifo_err_ovr_b = 1'b0;

  logic [3:0]  ack_a, ack_b;
  logic        wr_a, wr_b;
  logic [7:0]  d_a, d_b;
  logic [2:0]  owner_a, owner_b;
  logic        locked_a, locked_b, trunc_a, trunc_b, err_a, err_b;
  logic [63:0] stats_a, stats_b;

  kv_srl_fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .req_d(req_d),
    .ack(ack_a), .fifo_wr_en(wr_a), .fifo_d(d_a), .fifo_full(fifo_full_a),
    .fifo_err_ovr(fifo_err_ovr_a), .owner(owner_a), .locked(locked_a),
    .trunc(trunc_a), .err(err_a), .stats(stats_a)
  );

  kv_srl_fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .req_d(req_d),
    .ack(ack_b), .fifo_wr_en(wr_b), .fifo_d(d_b), .fifo_full(fifo_full_b),
    .fifo_err_ovr(fifo_err_ovr_b), .owner(owner_b), .locked(locked_b),
    .trunc(trunc_b), .err(err_b), .stats(stats_b)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  rq [4][$];   // per-requester beats {last, data}
  exp_t        exp_q[$];
  logic [7:0]  rd_exp[$];
  logic [7:0]  fifo_q[$];
  logic        sel_b = 1'b0;
  logic        rd_en = 1'b0;
  logic        rd_chk = 1'b0;
  logic        inj_ovr = 1'b0;
  logic [3:0]  last_ack = '0;
  int          wr_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 4; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic load(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_beat(input int r, input logic [7:0] d, input logic lk, input logic tr);
    exp_t e;
    e.ack    = 4'b0001 << r;
    e.d      = d;
    e.locked = lk;
    e.trunc  = tr;
    exp_q.push_back(e);
  endtask

  // One clock: drive requesters, sample mid-low phase, score, then update the FIFO model.
  task automatic step();
    exp_t       e;
    logic [3:0] ack_s;
    logic       wr_s, lk_s, tr_s, rst_s, wa, rd_s, fa, ovr;
    logic [7:0] d_s, da, rdat;
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        req[i]            = 1'b1;
        req_d[i*8 +: 8]   = rq[i][0][7:0];
        req_last[i]       = rq[i][0][8];
      end else begin
        req[i]            = 1'b0;
        req_d[i*8 +: 8]   = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    #2;
    ack_s = sel_b ? ack_b    : ack_a;
    wr_s  = sel_b ? wr_b     : wr_a;
    d_s   = sel_b ? d_b      : d_a;
    lk_s  = sel_b ? locked_b : locked_a;
    tr_s  = sel_b ? trunc_b  : trunc_a;
    last_ack = ack_s;
    if (wr_s) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("sb_extra_write", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("ack", ack_s, e.ack);
        check("data", d_s, e.d);
        check("locked", lk_s, e.locked);
        check("trunc", tr_s, e.trunc);
      end
    end
    for (int i = 0; i < 4; i++)
      if (ack_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    rst_s = rst_n; wa = wr_a; da = d_a; rd_s = rd_en; fa = fifo_full_a;
    @(posedge clk);
    #1;
    ovr = 1'b0;
    if (!rst_s) begin
      fifo_q.delete();
    end else begin
      if (rd_s && fifo_q.size() > 0) begin
        rdat = fifo_q.pop_front();
        if (rd_chk) begin
          if (rd_exp.size() == 0) check("rd_extra", rd_exp.size(), 1);
          else check("rd_order", rdat, rd_exp.pop_front());
        end
      end
      if (wa) begin
        if (fa) ovr = 1'b1;
        else fifo_q.push_back(da);
      end
    end
    fifo_full_a    = (fifo_q.size() == DEPTH);
    fifo_err_ovr_a = ovr | inj_ovr;
    @(negedge clk);
  endtask

  task automatic run(input int max_cycles);
    int n = 0;
    while (pending() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check("timeout", pending(), 0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) rq[i].delete();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_ack", ack_a, 0);
    check("rst_wr_en", wr_a, 0);
    check("rst_owner", owner_a, 0);
    check("rst_locked", locked_a, 0);
    check("rst_trunc", trunc_a, 0);
    check("rst_err", err_a, 0);
    check("rst_stats", stats_a, 0);
    check("rst_locked_b", locked_b, 0);

    // Fairness: all four requesting single beats, FIFO drained every cycle.
    rd_en = 1'b1; rd_chk = 1'b1;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 4; i++) begin
        load(i, 8'(i*16 + b), 1'b1);
        expect_beat(i, 8'(i*16 + b), 1'b0, 1'b0);
        rd_exp.push_back(8'(i*16 + b));
      end
    run(40);
    repeat (3) step();
    check("rd_drain", rd_exp.size(), 0);
    check("fair_owner", owner_a, 3);
    check("sb_drain_fair", exp_q.size(), 0);
    rd_chk = 1'b0;

    // Burst lock: req0 five beats while req1 keeps requesting.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      load(0, 8'(8'h10 + k), (k == 4));
      expect_beat(0, 8'(8'h10 + k), (k != 0), 1'b0);
    end
    load(1, 8'h20, 1'b1); load(1, 8'h21, 1'b1);
    expect_beat(1, 8'h20, 1'b0, 1'b0);
    expect_beat(1, 8'h21, 1'b0, 1'b0);
    run(30);
    check("lock_released", locked_a, 0);
    check("lock_owner", owner_a, 1);
    check("sb_drain_lock", exp_q.size(), 0);

    // Truncation at MAX_BURST=4, watched on the second instance.
    do_reset();
    sel_b = 1'b1;
    for (int k = 0; k < 6; k++) load(2, 8'(8'h30 + k), 1'b0);
    load(3, 8'h40, 1'b1);
    expect_beat(2, 8'h30, 1'b0, 1'b0);
    expect_beat(2, 8'h31, 1'b1, 1'b0);
    expect_beat(2, 8'h32, 1'b1, 1'b0);
    expect_beat(2, 8'h33, 1'b1, 1'b0);
    expect_beat(3, 8'h40, 1'b0, 1'b1);
    expect_beat(2, 8'h34, 1'b0, 1'b0);
    expect_beat(2, 8'h35, 1'b1, 1'b0);
    run(30);
    repeat (3) step();
    check("idle_owner_keeps_lock", locked_b, 1);
    check("idle_owner", owner_b, 2);
    load(0, 8'h50, 1'b1);
    load(2, 8'h36, 1'b1);
    expect_beat(2, 8'h36, 1'b1, 1'b0);
    expect_beat(0, 8'h50, 1'b0, 1'b0);
    run(20);
    check("trunc_idle", trunc_b, 0);
    check("sb_drain_trunc", exp_q.size(), 0);
    sel_b = 1'b0;

    // Backpressure: no reads until the FIFO is full.
    do_reset();
    rd_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      load(0, 8'(8'h60 + k), 1'b1);
      expect_beat(0, 8'(8'h60 + k), 1'b0, 1'b0);
    end
    wr_count = 0;
    repeat (12) step();
    check("fill_count", wr_count, DEPTH);
    check("ack_at_full", ack_a, 0);
    check("wr_at_full", wr_a, 0);
    check("err_at_full", err_a, 0);
    check("owner_at_full", owner_a, 0);
    wr_count = 0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    repeat (4) step();
    check("one_more_ack", wr_count, 1);
    rd_en = 1'b1;
    run(20);
    check("sb_drain_bp", exp_q.size(), 0);

    // Reset during req1's third beat.
    do_reset();
    for (int k = 0; k < 5; k++) load(1, 8'(8'h70 + k), (k == 4));
    expect_beat(1, 8'h70, 1'b0, 1'b0);
    expect_beat(1, 8'h71, 1'b1, 1'b0);
    step();
    step();
    load(0, 8'h80, 1'b1);
    rst_n = 1'b0;
    step();
    check("ack_in_reset", last_ack, 0);
    check("rst_mid_locked", locked_a, 0);
    check("rst_mid_owner", owner_a, 0);
    rst_n = 1'b1;
    expect_beat(0, 8'h80, 1'b0, 1'b0);
    expect_beat(1, 8'h72, 1'b0, 1'b0);
    expect_beat(1, 8'h73, 1'b1, 1'b0);
    expect_beat(1, 8'h74, 1'b1, 1'b0);
    run(20);
    check("sb_drain_rst", exp_q.size(), 0);

    // Beat counters: 40 beats from req1.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      load(1, 8'(k), 1'b1);
      expect_beat(1, 8'(k), 1'b0, 1'b0);
    end
    run(100);
    check("sb_drain_stats", exp_q.size(), 0);
`ifdef KV_SRL_FIFO_WR_ARB_STATS_EN
    check("stats_req1", stats_a[31:16], 40);
    check("stats_others", {stats_a[63:32], stats_a[15:0]}, 0);
`else
    check("stats_off", stats_a, 0);
`endif

    // Sticky err from a FIFO overflow report.
    check("err_before", err_a, 0);
    inj_ovr = 1'b1;
    step();
    inj_ovr = 1'b0;
    check("err_not_yet", err_a, 0);
    step();
    check("err_set", err_a, 1);
    repeat (2) step();
    check("err_sticky", err_a, 1);
    do_reset();
    check("err_cleared", err_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
